// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the rk2040 pipeline stage register.
//   pipe_state_e : stage occupancy state (EMPTY / BUSY / FULL)
//   OCC_W        : width of the occupancy count output
//   CTRL_NOP     : control value presented downstream when no entry is valid
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned OCC_W    = 2;
    localparam int unsigned CTRL_NOP = 0;

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// Load-enabled storage register for one pipeline entry (ctrl + payload).
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset, clears the slot to 0
//   i_load  in   capture i_d at the next rising edge
//   i_d     in   W-bit entry to store
//   o_q     out  W-bit stored entry
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int unsigned W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Entry storage; holds its value until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline stage register with synchronous flush and NOP masking of
// control bits. With PIPE_STAGE_SKID_EN defined the stage has a 2-entry skid
// buffer and a registered in_ready; otherwise it is a single slot whose
// in_ready is combinational (~out_valid | out_ready).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept
//   in_ctrl    in   CTRL_W upstream control bits
//   in_data    in   DATA_W upstream payload
//   out_valid  out  entry presented downstream
//   out_ready  in   downstream accepts
//   out_ctrl   out  CTRL_W control bits, 0 when out_valid=0
//   out_data   out  DATA_W payload, meaningful only when out_valid=1
//   occ        out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ
);

    localparam int unsigned SLOT_W = DATA_W + CTRL_W;

    pipe_state_e       r_state;
    logic              r_out_valid;
    logic [OCC_W-1:0]  r_occ;

    logic              w_accept;
    logic              w_drain;
    logic              w_main_load;
    logic [SLOT_W-1:0] w_in_slot;
    logic [SLOT_W-1:0] w_main_d;
    logic [SLOT_W-1:0] w_main_q;

    assign w_in_slot = {in_ctrl, in_data};
    assign w_drain   = r_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              r_in_ready;
    logic              w_skid_load;
    logic [SLOT_W-1:0] w_skid_q;

    assign w_accept = in_valid & r_in_ready;
    assign in_ready = r_in_ready;

    // Slot load steering; flush suppresses all loads.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = w_in_slot;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_main_load = w_accept;
                ST_BUSY: begin
                    w_main_load = w_accept & w_drain;
                    w_skid_load = w_accept & ~w_drain;
                end
                ST_FULL: begin
                    // Skid entry moves forward when the main entry drains.
                    w_main_load = w_drain;
                    w_main_d    = w_skid_q;
                end
                default: begin
                    w_main_load = 1'b0;
                end
            endcase
        end
    end

    // Occupancy FSM; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= OCC_W'(0);
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= OCC_W'(0);
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_BUSY;
                        r_out_valid <= 1'b1;
                        r_occ       <= OCC_W'(1);
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && !w_drain) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_occ       <= OCC_W'(2);
                        r_in_ready  <= 1'b0;
                    end else if (!w_accept && w_drain) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= OCC_W'(0);
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        r_state     <= ST_BUSY;
                        r_out_valid <= 1'b1;
                        r_occ       <= OCC_W'(1);
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_occ       <= OCC_W'(0);
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.W(SLOT_W)) u_skid_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_d    (w_in_slot),
        .o_q    (w_skid_q)
    );

`else

    // Single slot: a held entry can be replaced in the cycle it drains.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_main_d    = w_in_slot;
        w_main_load = w_accept & ~flush;
    end

    // Occupancy FSM restricted to EMPTY/BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= OCC_W'(0);
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= OCC_W'(0);
        end else if (w_accept) begin
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b1;
            r_occ       <= OCC_W'(1);
        end else if (w_drain) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= OCC_W'(0);
        end
    end

`endif

    pipe_slot #(.W(SLOT_W)) u_main_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    // Control bits are masked to NOP whenever nothing valid is presented.
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_valid ? w_main_q[SLOT_W-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
    assign out_data  = w_main_q[DATA_W-1:0];
    assign occ       = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed self-checking bench for pipe_stage_reg (default parameters).
// Expectations follow the skid or single-slot behaviour selected by
// PIPE_STAGE_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 8;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occ;

    int n_tests;
    int n_fail;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_data",  out_data,       64'd0);
        check("rst_occ",   64'(occ),       64'd0);
        step();
        step();
        #2 rst = 1'b0;
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming 1..8, one cycle latency, no bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            in_data = 64'(i);
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data",  out_data,       64'(i));
            check("stream_ctrl",  64'(out_ctrl),  64'h01);
            check("stream_occ",   64'(occ),       64'd1);
            check("stream_rdy",   64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_valid", 64'(out_valid), 64'd0);
        check("stream_end_ctrl",  64'(out_ctrl),  64'd0);
        check("stream_end_occ",   64'(occ),       64'd0);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h02;
        in_data   = 64'h11;
        step();
        check("bp_data0", out_data,     64'h11);
        check("bp_occ0",  64'(occ),     64'd1);
`ifdef PIPE_STAGE_SKID_EN
        check("bp_rdy0",  64'(in_ready), 64'd1);
        in_data = 64'h22;
        step();
        check("bp_occ_full", 64'(occ),      64'd2);
        check("bp_rdy_full", 64'(in_ready), 64'd0);
        check("bp_data1",    out_data,      64'h11);
        in_data = 64'h33;
        step();
        check("bp_hold_occ",  64'(occ), 64'd2);
        check("bp_hold_data", out_data, 64'h11);
        out_ready = 1'b1;
        step();
        check("bp_out_22", out_data,      64'h22);
        check("bp_occ_22", 64'(occ),      64'd1);
        check("bp_rdy_22", 64'(in_ready), 64'd1);
        step();
        check("bp_out_33",   out_data,       64'h33);
        check("bp_valid_33", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(out_valid), 64'd0);
`else
        in_data = 64'h22;
        #1;
        check("ns_rdy_held", 64'(in_ready), 64'd0);
        step();
        check("ns_hold_data", out_data, 64'h11);
        check("ns_hold_occ",  64'(occ), 64'd1);
        out_ready = 1'b1;
        #1;
        check("ns_rdy_comb", 64'(in_ready), 64'd1);
        step();
        check("ns_swap_data", out_data,       64'h22);
        check("ns_swap_occ",  64'(occ),       64'd1);
        check("ns_swap_vld",  64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        check("ns_drained", 64'(out_valid), 64'd0);
`endif

        // Flush with held entries and out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h04;
        in_data   = 64'hA1;
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 64'hA2;
        step();
        check("fl_pre_occ", 64'(occ), 64'd2);
`endif
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_occ",   64'(occ),       64'd0);
        check("fl_rdy",   64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_ghost", 64'(out_valid), 64'd0);
        end

        // Accept during flush is discarded
        in_valid = 1'b1;
        in_data  = 64'h55;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_acc_valid", 64'(out_valid), 64'd0);
        step();
        check("fl_acc_later", 64'(out_valid), 64'd0);

        // Control masking after drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 64'hFF;
        step();
        check("mask_ctrl_on", 64'(out_ctrl), 64'hFF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("mask_valid", 64'(out_valid), 64'd0);
        check("mask_ctrl",  64'(out_ctrl),  64'd0);

        // Reset asserted mid-cycle while holding an entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h08;
        in_data   = 64'h77;
        step();
        in_valid = 1'b0;
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ctrl",  64'(out_ctrl),  64'd0);
        check("mid_rst_occ",   64'(occ),       64'd0);
        check("mid_rst_data",  out_data,       64'd0);
        step();
        #2 rst = 1'b0;
        step();
        check("mid_rst_rdy",  64'(in_ready),  64'd1);
        check("mid_rst_post", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the rk2040 datapath. It replaces the fixed-field, always-advancing stage registers with a generic payload register that supports valid/ready back-pressure, a synchronous flush, and a 2-entry skid buffer. Control bits are forced to zero whenever the stage holds no valid instruction, so downstream sees a NOP. One instance sits between each pair of adjacent pipeline stages.

## Interface
- DATA_W, default 64: width of payload not subject to masking (operands, address, pcInc, RT, aluOp).
- CTRL_W, default 8: width of control bits (branch/load/store/push/pop and similar); forced to 0 when not valid.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bits; 0 when out_valid=0.
- out_data  out  DATA_W  payload; meaningful only when out_valid=1.
- occ  out  2  number of held entries (0..2).

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- States (skid mode): EMPTY (occ 0), BUSY (main slot valid, occ 1), FULL (main and skid slots valid, occ 2).
- Transitions:
  - EMPTY: accept → BUSY, main ← in.
  - BUSY: accept & drain → BUSY, main ← in. Accept only → FULL, skid ← in. Drain only → EMPTY.
  - FULL: drain → BUSY, main ← skid. Otherwise hold.
- in_ready is registered: 1 in EMPTY and BUSY, 0 in FULL.
- out_valid = state ≠ EMPTY. out_data/out_ctrl always come from the main slot.
- out_ctrl = out_valid ? main_ctrl : 0, applied combinationally at the output.
- Flush has highest priority. Next state is EMPTY and occ becomes 0.
  - An accept in the flush cycle counts as transferred and is discarded.
  - A drain in the flush cycle counts as consumed.
- Ordering is strictly FIFO. No entry is duplicated or reordered.
- Reset values: out_valid 0, out_ctrl 0, out_data 0, occ 0, in_ready 1, both slots 0, state EMPTY.
- A reset asserted mid-operation discards all entries immediately.

## Timing
- Latency is 1 cycle: data accepted at edge N is visible on out_* after edge N.
- Throughput is 1 entry/cycle sustained with out_ready=1.
- With back-pressure, in_ready deasserts only after the edge on which the skid slot fills. There is no combinational path from out_ready to in_ready.
- flush takes effect at the next rising edge. Outputs show out_valid=0 and out_ctrl=0 after that edge.
- rst acts asynchronously on assertion. Deassertion is assumed synchronised externally.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid behaviour as above, with registered in_ready.
- PIPE_STAGE_SKID_EN undefined: single slot (EMPTY/BUSY only).
  - in_ready = ~out_valid | out_ready, combinational.
  - occ never exceeds 1.
  - Flush, masking, reset and latency rules are unchanged.

## Structure
- Package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_BUSY, ST_FULL)
  - OCC_W = 2
  - a NOP control constant CTRL_NOP = 0, used for masking.
- One sub-module, pipe_slot: a load-enabled DATA_W+CTRL_W register with async reset. It is instantiated twice for main and skid (once when the macro is off).

## Test plan
- Reset: assert rst mid-cycle → immediately out_valid=0, out_ctrl=0, occ=0. After release, in_ready=1.
- Streaming: in_valid=1 with data 1..8, ctrl 0x01, out_ready=1 → out_data 1..8 on consecutive cycles, one cycle delayed, no bubbles.
- Back-pressure: out_ready=0, push 0x11 then 0x22 → occ=2, in_ready=0. Present 0x33 and hold it, then raise out_ready → outputs 0x11, 0x22, 0x33 in order.
- Flush in FULL with out_ready=0 → next cycle out_valid=0, out_ctrl=0, occ=0, in_ready=1. Neither flushed entry ever appears.
- Masking: load ctrl=0xFF, drain with no new input → out_ctrl=0 once out_valid=0. out_data may retain 0xFF-cycle payload.
- Macro off: entry held with out_ready=0 → in_ready=0 in the same cycle. Raise out_ready with in_valid=1 → simultaneous drain and accept, occ stays 1.
